// File: rtl/k16_panel_scan.sv
// Front-panel scanner: walks 8 slots at a fixed rate, drives the LED nibble for each
// slot, assembles the switch nibbles into frames and debounces them frame-by-frame.
module k16_panel_scan #(
    parameter int DIVISOR  = 500000,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  io_switches,
    input  logic [15:0] addr_leds,
    input  logic [15:0] data_leds,
    output logic [2:0]  io_addr,
    output logic [3:0]  io_leds,
    output logic [15:0] addr_switches,
    output logic [15:0] ctrl_switches,
    output logic [15:0] ctrl_event,
    output logic        frame_done
);
    localparam logic [31:0] DIV_LAST      = 32'(DIVISOR - 1);
    localparam logic [3:0]  MATCH_MAX     = 4'(DEBOUNCE - 1);
    localparam logic [3:0]  COMMIT_AT     = 4'((DEBOUNCE >= 2) ? DEBOUNCE - 2 : 0);
    localparam bit          ALWAYS_COMMIT = (DEBOUNCE == 1);

    logic [31:0] r_count;
    logic [2:0]  r_addr;
    logic [3:0]  r_leds;
    logic [31:0] r_raw;
    logic [31:0] r_prev;
    logic [3:0]  r_match;
    logic [15:0] r_addr_sw;
    logic [15:0] r_ctrl_sw;
    logic [15:0] r_event;
    logic        r_done;
    logic        r_done_pend;
    logic        r_commit_pend;
    logic [31:0] r_pend_frame;

    logic        w_tick;
    logic [2:0]  w_next_addr;
    logic [31:0] w_frame;
    logic [31:0] w_led_word;
    logic [3:0]  w_led_nibble;
    logic        w_frame_end;
    logic        w_same;
    logic        w_commit;

    assign w_tick      = (r_count == DIV_LAST);
    assign w_next_addr = r_addr + 3'd1;
    assign w_frame_end = w_tick && (r_addr == 3'd7);
    assign w_led_word  = {data_leds, addr_leds};

    // Frame layout: slots 0-3 fill the address half [15:0], slots 4-7 the control half [31:16].
    always_comb begin
        w_frame = r_raw;
        w_frame[{r_addr, 2'b00} +: 4] = ~io_switches;
    end

    always_comb begin
        w_led_nibble = w_led_word[{w_next_addr, 2'b00} +: 4];
    end

    assign w_same   = (w_frame == r_prev);
    assign w_commit = ALWAYS_COMMIT || (w_same && (r_match == COMMIT_AT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= 32'd0;
            r_addr        <= 3'd0;
            r_leds        <= 4'd0;
            r_raw         <= 32'd0;
            r_prev        <= 32'd0;
            r_match       <= 4'd0;
            r_addr_sw     <= 16'd0;
            r_ctrl_sw     <= 16'd0;
            r_event       <= 16'd0;
            r_done        <= 1'b0;
            r_done_pend   <= 1'b0;
            r_commit_pend <= 1'b0;
            r_pend_frame  <= 32'd0;
        end else begin
            r_count       <= w_tick ? 32'd0 : r_count + 32'd1;
            r_done_pend   <= w_frame_end;
            r_commit_pend <= w_frame_end && w_commit;

            if (w_tick) begin
                r_raw  <= w_frame;
                r_addr <= w_next_addr;
                r_leds <= w_led_nibble;
            end

            if (w_frame_end) begin
                r_prev       <= w_frame;
                r_pend_frame <= w_frame;
                if (!w_same) begin
                    r_match <= 4'd0;
                end else if (r_match != MATCH_MAX) begin
                    r_match <= r_match + 4'd1;
                end
            end

            // Commit lands one clock after the frame-end edge, together with frame_done.
            r_done  <= r_done_pend;
            r_event <= r_commit_pend ? (r_pend_frame[31:16] & ~r_ctrl_sw) : 16'd0;
            if (r_commit_pend) begin
                r_addr_sw <= r_pend_frame[15:0];
                r_ctrl_sw <= r_pend_frame[31:16];
            end
        end
    end

    assign io_addr       = r_addr;
    assign io_leds       = r_leds;
    assign addr_switches = r_addr_sw;
    assign ctrl_switches = r_ctrl_sw;
    assign ctrl_event    = r_event;
    assign frame_done    = r_done;
endmodule

// File: tb/tb_k16_panel_scan.sv
// Directed bench for k16_panel_scan with DIVISOR=4, DEBOUNCE=2 (one frame = 32 clocks).
// A small panel model returns the switch nibble for whichever slot the scanner selects.
module tb_k16_panel_scan;
    logic        clk;
    logic        reset;
    logic [3:0]  io_switches;
    logic [15:0] addr_leds;
    logic [15:0] data_leds;
    logic [2:0]  io_addr;
    logic [3:0]  io_leds;
    logic [15:0] addr_switches;
    logic [15:0] ctrl_switches;
    logic [15:0] ctrl_event;
    logic        frame_done;

    logic [3:0]  panel [8];
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          ev_count;
    logic [15:0] ev_or;
    int          fd_count;

    k16_panel_scan #(.DIVISOR(4), .DEBOUNCE(2)) dut (
        .clk(clk), .reset(reset), .io_switches(io_switches),
        .addr_leds(addr_leds), .data_leds(data_leds),
        .io_addr(io_addr), .io_leds(io_leds),
        .addr_switches(addr_switches), .ctrl_switches(ctrl_switches),
        .ctrl_event(ctrl_event), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low switches: 4'hF means nothing pressed in that slot.
    assign io_switches = panel[io_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One rising edge, then sample 1 ns later; also tallies pulses for window checks.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ctrl_event != 16'd0) begin
            ev_count++;
            ev_or = ev_or | ctrl_event;
        end
        if (frame_done) fd_count++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_tallies();
        ev_count = 0;
        ev_or    = 16'd0;
        fd_count = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_io_addr"},  32'(io_addr), 32'd0);
        check({tag, "_io_leds"},  32'(io_leds), 32'd0);
        check({tag, "_addr_sw"},  32'(addr_switches), 32'd0);
        check({tag, "_ctrl_sw"},  32'(ctrl_switches), 32'd0);
        check({tag, "_event"},    32'(ctrl_event), 32'd0);
        check({tag, "_fdone"},    32'(frame_done), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_leds [8];
        int bad;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        clear_tallies();
        exp_leds = '{4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA, 4'h4};
        for (int i = 0; i < 8; i++) panel[i] = 4'hF;
        panel[0]  = 4'hA;
        addr_leds = 16'h1234;
        data_leds = 16'hABCD;
        reset     = 1'b1;

        // Reset state and first tick position
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        cyc   = 0;
        clear_tallies();
        repeat (3) step();
        check("addr_before_tick", 32'(io_addr), 32'd0);
        step();
        check("first_tick_addr", 32'(io_addr), 32'd1);
        check("led_slot1", 32'(io_leds), 32'(exp_leds[0]));

        // LED mux across the rest of the first frame
        for (int k = 2; k <= 8; k++) begin
            repeat (4) step();
            check($sformatf("addr_slot%0d", k % 8), 32'(io_addr), 32'(k % 8));
            check($sformatf("led_slot%0d", k % 8), 32'(io_leds), 32'(exp_leds[k - 1]));
        end
        check("fdone_none_before_32", 32'(fd_count), 32'd0);
        step();
        check("fdone_at_33", 32'(frame_done), 32'd1);
        check("no_commit_frame1", 32'(addr_switches), 32'd0);
        step();
        check("fdone_one_clk", 32'(frame_done), 32'd0);

        // Debounce: second identical frame commits one clock after its end
        run_to(64);
        check("no_commit_at_frame_end", 32'(addr_switches), 32'd0);
        step();
        check("commit_frame2", 32'(addr_switches), 32'h0005);
        check("fdone_frame2", 32'(frame_done), 32'd1);

        // Glitch: one frame with slot 0 released must not disturb the committed value
        panel[0] = 4'hF;
        bad = 0;
        while (cyc < 96) begin
            step();
            if (addr_switches !== 16'h0005) bad++;
        end
        panel[0] = 4'hA;
        while (cyc < 170) begin
            step();
            if (addr_switches !== 16'h0005) bad++;
        end
        check("glitch_hold", 32'(bad), 32'd0);

        // Events: press ctrl bit 5 (slot 5, nibble 4'hD)
        run_to(192);
        clear_tallies();
        panel[5] = 4'hD;
        run_to(256);
        check("ev_before_commit", 32'(ctrl_event), 32'd0);
        check("ctrl_before_commit", 32'(ctrl_switches), 32'd0);
        step();
        check("ev_press", 32'(ctrl_event), 32'h0020);
        check("ctrl_press", 32'(ctrl_switches), 32'h0020);
        step();
        check("ev_one_clk", 32'(ctrl_event), 32'd0);
        run_to(320);
        check("ev_held_count", 32'(ev_count), 32'd1);
        check("ev_held_bits", 32'(ev_or), 32'h0020);
        panel[5] = 4'hF;
        run_to(384);
        check("ctrl_before_release", 32'(ctrl_switches), 32'h0020);
        step();
        check("ctrl_release", 32'(ctrl_switches), 32'd0);
        run_to(416);
        check("ev_release_none", 32'(ev_count), 32'd1);
        panel[5] = 4'hD;
        run_to(480);
        step();
        check("ev_repress", 32'(ctrl_event), 32'h0020);
        step();
        check("ev_repress_count", 32'(ev_count), 32'd2);

        // Reset mid-frame at slot 3 with the match counter already saturated
        run_to(512);
        repeat (12) step();
        check("pre_reset_slot", 32'(io_addr), 32'd3);
        clear_tallies();
        reset = 1'b1;
        repeat (2) step();
        check_all_zero("midreset");
        reset = 1'b0;
        cyc   = 0;
        run_to(33);
        check("rst_no_commit_frame1", 32'(addr_switches), 32'd0);
        check("rst_ev_none", 32'(ev_count), 32'd0);
        run_to(65);
        check("rst_commit_addr", 32'(addr_switches), 32'h0005);
        check("rst_commit_ctrl", 32'(ctrl_switches), 32'h0020);
        check("rst_commit_ev", 32'(ctrl_event), 32'h0020);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
